// File: rtl/fir_xifu_lsu_ctrl.sv
// Load/store scheduler for the FIR XIFU: holds EX requests until commit/kill, issues committed
// ones to the X-interface memory channel in order, and turns in-order results into WB records.
module fir_xifu_lsu_ctrl #(
    parameter int DEPTH    = 4,
    parameter int ID_WIDTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [ID_WIDTH-1:0]        req_id_i,
    input  logic [31:0]                req_addr_i,
    input  logic                       req_we_i,
    input  logic [31:0]                req_wdata_i,
    input  logic [4:0]                 req_rd_i,
    input  logic                       commit_valid_i,
    input  logic [ID_WIDTH-1:0]        commit_id_i,
    input  logic                       commit_kill_i,
    output logic                       mem_valid_o,
    input  logic                       mem_ready_i,
    output logic [ID_WIDTH-1:0]        mem_id_o,
    output logic [31:0]                mem_addr_o,
    output logic                       mem_we_o,
    output logic [31:0]                mem_wdata_o,
    output logic [3:0]                 mem_be_o,
    input  logic                       memres_valid_i,
    input  logic [31:0]                memres_rdata_i,
    input  logic                       memres_err_i,
    output logic                       wb_valid_o,
    output logic [ID_WIDTH-1:0]        wb_id_o,
    output logic [4:0]                 wb_rd_o,
    output logic                       wb_rd_we_o,
    output logic [31:0]                wb_data_o,
    output logic                       wb_err_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       proto_err_o,
    output logic [3*DEPTH-1:0]         dbg_slot_state_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {S_FREE, S_PEND, S_CMT, S_KILL, S_ISSUED} slot_state_e;

    slot_state_e         st_q [DEPTH];
    slot_state_e         st_d [DEPTH];
    logic [ID_WIDTH-1:0] id_q    [DEPTH];
    logic [31:0]         addr_q  [DEPTH];
    logic                we_q    [DEPTH];
    logic [31:0]         wdata_q [DEPTH];
    logic [4:0]          rd_q    [DEPTH];

    logic [AW-1:0]    alloc_ptr_q, issue_ptr_q, retire_ptr;
    logic             retire_found, retire_fire;
    logic             req_fire, mem_fire, kill_skip, req_hit, commit_hit;
    logic [DEPTH-1:0] pend_hit;
    logic [CW-1:0]    count;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and a raised mem_valid_o holds its fields until accepted.
    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (st_q[i] != S_FREE) count = count + CW'(1);
        end
    end

    // A skipped kill can leave a freed hole behind an issued slot, so the tail slot itself
    // must also be free before a new request is taken.
    assign count_o     = count;
    assign req_ready_o = (count < CW'(DEPTH)) && (st_q[alloc_ptr_q] == S_FREE);
    assign req_fire    = req_valid_i && req_ready_o;

    assign mem_valid_o = (st_q[issue_ptr_q] == S_CMT);
    assign mem_id_o    = id_q[issue_ptr_q];
    assign mem_addr_o  = addr_q[issue_ptr_q];
    assign mem_we_o    = we_q[issue_ptr_q];
    assign mem_wdata_o = wdata_q[issue_ptr_q];
    assign mem_be_o    = 4'b1111;
    assign mem_fire    = mem_valid_o && mem_ready_i;
    assign kill_skip   = (st_q[issue_ptr_q] == S_KILL);

    // Scanning forward from the tail visits slots oldest first, so the first ISSUED hit is
    // the one the next result belongs to.
    always_comb begin
        logic [AW-1:0] idx;
        retire_found = 1'b0;
        retire_ptr   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = alloc_ptr_q + AW'(k);
            if (!retire_found && st_q[idx] == S_ISSUED) begin
                retire_found = 1'b1;
                retire_ptr   = idx;
            end
        end
    end
    assign retire_fire = memres_valid_i && retire_found;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            st_d[i]     = st_q[i];
            pend_hit[i] = commit_valid_i && (st_q[i] == S_PEND) && (id_q[i] == commit_id_i);
        end
        req_hit    = req_fire && commit_valid_i && (req_id_i == commit_id_i);
        commit_hit = commit_valid_i && ((|pend_hit) || req_hit);

        if (req_fire) st_d[alloc_ptr_q] = req_hit ? (commit_kill_i ? S_KILL : S_CMT) : S_PEND;
        for (int i = 0; i < DEPTH; i++) begin
            if (pend_hit[i]) st_d[i] = commit_kill_i ? S_KILL : S_CMT;
        end
        if (mem_fire)    st_d[issue_ptr_q] = S_ISSUED;
        if (kill_skip)   st_d[issue_ptr_q] = S_FREE;
        if (retire_fire) st_d[retire_ptr]  = S_FREE;
    end

    always_comb begin
        dbg_slot_state_o = '0;
        for (int i = 0; i < DEPTH; i++) dbg_slot_state_o[3*i +: 3] = st_q[i];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                st_q[i]    <= S_FREE;
                id_q[i]    <= '0;
                addr_q[i]  <= '0;
                we_q[i]    <= 1'b0;
                wdata_q[i] <= '0;
                rd_q[i]    <= '0;
            end
            alloc_ptr_q <= '0;
            issue_ptr_q <= '0;
            wb_valid_o  <= 1'b0;
            wb_id_o     <= '0;
            wb_rd_o     <= '0;
            wb_rd_we_o  <= 1'b0;
            wb_data_o   <= '0;
            wb_err_o    <= 1'b0;
            proto_err_o <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) st_q[i] <= st_d[i];
            if (req_fire) begin
                id_q[alloc_ptr_q]    <= req_id_i;
                addr_q[alloc_ptr_q]  <= req_addr_i;
                we_q[alloc_ptr_q]    <= req_we_i;
                wdata_q[alloc_ptr_q] <= req_wdata_i;
                rd_q[alloc_ptr_q]    <= req_rd_i;
                alloc_ptr_q          <= alloc_ptr_q + AW'(1);
            end
            if (mem_fire || kill_skip) issue_ptr_q <= issue_ptr_q + AW'(1);
            wb_valid_o <= retire_fire;
            if (retire_fire) begin
                wb_id_o    <= id_q[retire_ptr];
                wb_rd_o    <= rd_q[retire_ptr];
                wb_rd_we_o <= !we_q[retire_ptr];
                wb_data_o  <= we_q[retire_ptr] ? 32'h0 : memres_rdata_i;
                wb_err_o   <= memres_err_i;
            end
            if ((commit_valid_i && !commit_hit) || (memres_valid_i && !retire_found))
                proto_err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fir_xifu_lsu_ctrl.sv
// Directed bench for fir_xifu_lsu_ctrl: expected memory requests and WB records are queued
// by the stimulus and consumed by independent monitors.
module tb_fir_xifu_lsu_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i, req_ready_o;
    logic [3:0]  req_id_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic        req_we_i;
    logic [4:0]  req_rd_i;
    logic        commit_valid_i, commit_kill_i;
    logic [3:0]  commit_id_i;
    logic        mem_valid_o, mem_ready_i, mem_we_o;
    logic [3:0]  mem_id_o, mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        memres_valid_i, memres_err_i;
    logic [31:0] memres_rdata_i;
    logic        wb_valid_o, wb_rd_we_o, wb_err_o;
    logic [3:0]  wb_id_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic [2:0]  count_o;
    logic        proto_err_o;
    logic [11:0] dbg_slot_state_o;

    int checks = 0;
    int errors = 0;
    logic [68:0] exp_mem_q[$];
    logic [42:0] exp_wb_q[$];

    fir_xifu_lsu_ctrl #(.DEPTH(4), .ID_WIDTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_id_i(req_id_i),
        .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_wdata_i(req_wdata_i),
        .req_rd_i(req_rd_i),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_id_o(mem_id_o),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
        .mem_be_o(mem_be_o),
        .memres_valid_i(memres_valid_i), .memres_rdata_i(memres_rdata_i),
        .memres_err_i(memres_err_i),
        .wb_valid_o(wb_valid_o), .wb_id_o(wb_id_o), .wb_rd_o(wb_rd_o), .wb_rd_we_o(wb_rd_we_o),
        .wb_data_o(wb_data_o), .wb_err_o(wb_err_o),
        .count_o(count_o), .proto_err_o(proto_err_o), .dbg_slot_state_o(dbg_slot_state_o)
    );

    // Clock and reset
    always #5 clk_i = ~clk_i;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    // Monitors
    always @(negedge clk_i) begin
        if (!rst_i && mem_valid_o && mem_ready_i) begin
            if (exp_mem_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_unexpected actual id=%0h addr=%0h expected none", mem_id_o, mem_addr_o);
            end else begin
                chk("mem_req", {mem_id_o, mem_addr_o, mem_we_o, mem_wdata_o}, exp_mem_q.pop_front());
                chk("mem_be", mem_be_o, 4'hF);
            end
        end
    end

    always @(negedge clk_i) begin
        if (!rst_i && wb_valid_o) begin
            if (exp_wb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected actual id=%0h expected none", wb_id_o);
            end else begin
                chk("wb_rec", {wb_id_o, wb_rd_o, wb_rd_we_o, wb_data_o, wb_err_o}, exp_wb_q.pop_front());
            end
        end
    end

    // Driver tasks
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        req_valid_i    = 1'b0;
        commit_valid_i = 1'b0;
        commit_kill_i  = 1'b0;
        memres_valid_i = 1'b0;
        memres_err_i   = 1'b0;
    endtask

    task automatic set_req(input logic [3:0] id, input logic [31:0] addr, input logic we,
                           input logic [31:0] wd, input logic [4:0] rd);
        chk("req_ready", req_ready_o, 1'b1);
        req_valid_i = 1'b1;
        req_id_i    = id;
        req_addr_i  = addr;
        req_we_i    = we;
        req_wdata_i = wd;
        req_rd_i    = rd;
    endtask

    task automatic set_commit(input logic [3:0] id, input logic kill);
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
    endtask

    task automatic set_res(input logic [31:0] rdata, input logic err);
        memres_valid_i = 1'b1;
        memres_rdata_i = rdata;
        memres_err_i   = err;
    endtask

    initial begin
        rst_i = 1'b1;
        idle();
        req_id_i = '0; req_addr_i = '0; req_we_i = 1'b0; req_wdata_i = '0; req_rd_i = '0;
        commit_id_i = '0; memres_rdata_i = '0; mem_ready_i = 1'b1;
        cyc(); cyc();
        rst_i = 1'b0;
        cyc();
        chk("rst_ready", req_ready_o, 1'b1);
        chk("rst_count", count_o, 3'd0);
        chk("rst_memv", mem_valid_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_be", mem_be_o, 4'hF);
        chk("rst_wbv", wb_valid_o, 1'b0);
        chk("rst_proto", proto_err_o, 1'b0);
        chk("rst_dbg", dbg_slot_state_o, 12'h0);

        // 1: single load
        set_req(4'd3, 32'h1000, 1'b0, 32'h0, 5'd5);
        cyc();
        idle();
        set_commit(4'd3, 1'b0);
        exp_mem_q.push_back({4'd3, 32'h1000, 1'b0, 32'h0});
        chk("t1_count", count_o, 3'd1);
        chk("t1_memv_early", mem_valid_o, 1'b0);
        cyc();
        idle();
        chk("t1_memv", mem_valid_o, 1'b1);
        cyc();
        set_res(32'hCAFE0001, 1'b0);
        exp_wb_q.push_back({4'd3, 5'd5, 1'b1, 32'hCAFE0001, 1'b0});
        cyc();
        idle();
        chk("t1_count_end", count_o, 3'd0);
        cyc();
        chk("t1_wb_pulse", wb_valid_o, 1'b0);

        // 2: fill all slots, then free one
        for (int i = 0; i < 4; i++) begin
            set_req(4'(i), 32'h100 + 32'(i * 4), 1'b0, 32'h0, 5'(10 + i));
            cyc();
        end
        idle();
        chk("t2_full_ready", req_ready_o, 1'b0);
        chk("t2_full_count", count_o, 3'd4);
        set_commit(4'd0, 1'b0);
        exp_mem_q.push_back({4'd0, 32'h100, 1'b0, 32'h0});
        cyc();
        idle();
        cyc();
        set_res(32'h0000_00A0, 1'b0);
        exp_wb_q.push_back({4'd0, 5'd10, 1'b1, 32'h0000_00A0, 1'b0});
        chk("t2_ready_before", req_ready_o, 1'b0);
        cyc();
        idle();
        chk("t2_ready_after", req_ready_o, 1'b1);
        chk("t2_count_after", count_o, 3'd3);
        for (int i = 1; i < 4; i++) begin
            set_commit(4'(i), 1'b1);
            cyc();
        end
        idle();
        cyc(); cyc();
        chk("t2_drained", count_o, 3'd0);

        // 3: kill in the middle
        for (int i = 1; i < 4; i++) begin
            set_req(4'(i), 32'h2000 + 32'(i * 4), 1'b0, 32'h0, 5'(i));
            cyc();
        end
        idle();
        set_commit(4'd2, 1'b1);
        cyc();
        set_commit(4'd1, 1'b0);
        exp_mem_q.push_back({4'd1, 32'h2004, 1'b0, 32'h0});
        cyc();
        set_commit(4'd3, 1'b0);
        exp_mem_q.push_back({4'd3, 32'h200C, 1'b0, 32'h0});
        cyc();
        idle();
        cyc(); cyc(); cyc();
        chk("t3_memq_empty", exp_mem_q.size(), 0);
        set_res(32'h1111_0001, 1'b0);
        exp_wb_q.push_back({4'd1, 5'd1, 1'b1, 32'h1111_0001, 1'b0});
        cyc();
        set_res(32'h3333_0003, 1'b0);
        exp_wb_q.push_back({4'd3, 5'd3, 1'b1, 32'h3333_0003, 1'b0});
        cyc();
        idle();
        cyc();
        chk("t3_count_end", count_o, 3'd0);

        // 4: same-cycle request and commit, then back-pressure
        set_req(4'd7, 32'h3000, 1'b0, 32'h0, 5'd7);
        set_commit(4'd7, 1'b0);
        exp_mem_q.push_back({4'd7, 32'h3000, 1'b0, 32'h0});
        cyc();
        idle();
        mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_memv_hold", mem_valid_o, 1'b1);
            chk("t4_id_hold", mem_id_o, 4'd7);
            chk("t4_addr_hold", mem_addr_o, 32'h3000);
            cyc();
        end
        mem_ready_i = 1'b1;
        cyc();
        set_res(32'h7777_0007, 1'b0);
        exp_wb_q.push_back({4'd7, 5'd7, 1'b1, 32'h7777_0007, 1'b0});
        cyc();
        idle();
        cyc();

        // 5: store with bus error
        set_req(4'd4, 32'h4000, 1'b1, 32'h1234_5678, 5'd9);
        cyc();
        idle();
        set_commit(4'd4, 1'b0);
        exp_mem_q.push_back({4'd4, 32'h4000, 1'b1, 32'h1234_5678});
        cyc();
        idle();
        chk("t5_we", mem_we_o, 1'b1);
        chk("t5_be", mem_be_o, 4'hF);
        cyc();
        set_res(32'hDEAD_BEEF, 1'b1);
        exp_wb_q.push_back({4'd4, 5'd9, 1'b0, 32'h0, 1'b1});
        cyc();
        idle();
        cyc();
        chk("t5_proto_clean", proto_err_o, 1'b0);

        // 6: stray result, reset mid-queue, stray commit, late result
        set_res(32'h5555_5555, 1'b0);
        cyc();
        idle();
        chk("t6_proto_stray", proto_err_o, 1'b1);
        set_req(4'd5, 32'h5000, 1'b0, 32'h0, 5'd5);
        set_commit(4'd5, 1'b0);
        exp_mem_q.push_back({4'd5, 32'h5000, 1'b0, 32'h0});
        cyc();
        idle();
        set_req(4'd6, 32'h6000, 1'b0, 32'h0, 5'd6);
        cyc();
        idle();
        chk("t6_count_mid", count_o, 3'd2);
        rst_i = 1'b1;
        #1;
        chk("t6_count_in_rst", count_o, 3'd0);
        cyc();
        rst_i = 1'b0;
        chk("t6_count_post", count_o, 3'd0);
        chk("t6_proto_post", proto_err_o, 1'b0);
        chk("t6_ready_post", req_ready_o, 1'b1);
        set_commit(4'd6, 1'b0);
        cyc();
        idle();
        chk("t6_proto_commit", proto_err_o, 1'b1);
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        chk("t6_proto_cleared", proto_err_o, 1'b0);
        set_res(32'h6666_6666, 1'b0);
        cyc();
        idle();
        chk("t6_proto_late", proto_err_o, 1'b1);
        chk("t6_no_wb", wb_valid_o, 1'b0);
        cyc();
        chk("t6_no_wb2", wb_valid_o, 1'b0);
        cyc();

        // Final report
        chk("end_mem_q", exp_mem_q.size(), 0);
        chk("end_wb_q", exp_wb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
